// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, ALU/WB/immediate
// select codes, RV32I major opcodes and the one-hot instruction class.
package multi_cycle_ctrl_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned OPC_WIDTH  = 7;
  localparam int unsigned CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_PASS_B = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // One-hot instruction class; all zero for an illegal opcode.
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic opimm;
    logic op;
  } op_class_t;

  function automatic logic is_mem_op(input op_class_t c);
    return c.load | c.store;
  endfunction

  function automatic logic is_jump(input op_class_t c);
    return c.jal | c.jalr;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_opcode_decode.sv
// Combinational RV32I major-opcode classifier: one-hot class, immediate format and legality.
module opcode_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_type,
  output logic       legal
);

  always_comb begin
    op_class = '0;
    imm_type = IMM_I;
    legal    = 1'b1;
    case (opcode)
      OPC_LUI:    begin op_class.lui    = 1'b1; imm_type = IMM_U; end
      OPC_AUIPC:  begin op_class.auipc  = 1'b1; imm_type = IMM_U; end
      OPC_JAL:    begin op_class.jal    = 1'b1; imm_type = IMM_J; end
      OPC_JALR:   begin op_class.jalr   = 1'b1; imm_type = IMM_I; end
      OPC_BRANCH: begin op_class.branch = 1'b1; imm_type = IMM_B; end
      OPC_LOAD:   begin op_class.load   = 1'b1; imm_type = IMM_I; end
      OPC_STORE:  begin op_class.store  = 1'b1; imm_type = IMM_S; end
      OPC_OPIMM:  begin op_class.opimm  = 1'b1; imm_type = IMM_I; end
      // Register-register ops use no immediate; I is reported as a harmless default.
      OPC_OP:     begin op_class.op     = 1'b1; imm_type = IMM_I; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/exec/mem/wb sequencing).
// Define MULTI_CYCLE_CTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  br_taken,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_is_data,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic [1:0]            alu_op,
  output logic [2:0]            imm_type,
  output logic                  trap,
  output logic [2:0]            state_o
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  instret_cnt
`endif
);

  state_t    state_q;
  state_t    state_d;
  op_class_t cls;
  logic      legal;

  // Timeout is reserved; only opcode bits drive decode.
  logic unused_c;
  assign unused_c = ^{32'(FETCH_TIMEOUT), inst[INST_WIDTH-1:OPC_WIDTH]};

  opcode_decode u_dec (
    .opcode   (inst[OPC_WIDTH-1:0]),
    .op_class (cls),
    .imm_type (imm_type),
    .legal    (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_data = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    alu_op      = ALU_ADD;
    trap        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        // alu_a_sel=1 picks the old-PC register captured with ir_we, not the live PC+4.
        if (cls.op) begin
          alu_op = ALU_FUNCT;
        end else if (cls.opimm) begin
          alu_b_sel = 1'b1;
          alu_op    = ALU_FUNCT;
        end else if (cls.lui) begin
          alu_b_sel = 1'b1;
          alu_op    = ALU_PASS_B;
        end else if (cls.auipc | cls.jal | cls.branch) begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end else if (is_mem_op(cls) | cls.jalr) begin
          alu_b_sel = 1'b1;
        end
        if (cls.branch) begin
          pc_we   = br_taken;
          pc_sel  = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem_op(cls)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = cls.store;
        if (mem_ready) state_d = cls.store ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        if (cls.load)          wb_sel = WB_MEM;
        else if (is_jump(cls)) wb_sel = WB_LINK;
        if (is_jump(cls)) begin
          pc_we  = 1'b1;
          pc_sel = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic retire_c;
  assign retire_c = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  // Both counters hold in IDLE and TRAP; retirement is any return to FETCH from a late stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_TRAP))
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (retire_c)
        instret_cnt <= instret_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl: instruction walk-throughs with
// wait states, branches, jumps, reset mid-MEM and illegal-opcode trap.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_is_data, ir_we, pc_we, pc_sel, reg_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel, alu_b_sel;
  logic [1:0]  alu_op;
  logic [2:0]  imm_type;
  logic        trap;
  logic [2:0]  state_o;
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] instret_snap, cycle_snap;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bad      = 0;
  int reg_we_cycles = 0;

  multi_cycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_is_data (mem_is_data),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .alu_op      (alu_op),
    .imm_type    (imm_type),
    .trap        (trap),
    .state_o     (state_o)
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reg_we) reg_we_cycles++;
  endtask

  initial begin
    rst = 1'b1; inst = 32'h00500093; br_taken = 1'b0; mem_ready = 1'b0;
    #12;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_strobes", {25'd0, mem_req, mem_we, ir_we, pc_we, reg_we, trap, mem_is_data}, 32'd0);
    check("rst_imm_addi", 32'(imm_type), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_state", 32'(state_o), 32'd0);

    // FETCH stalled on mem_ready=0
    tick();
    check("fetch_state", 32'(state_o), 32'd1);
    check("fetch_wait_req", {30'd0, mem_req, mem_is_data}, 32'b10);
    check("fetch_wait_noload", {30'd0, ir_we, pc_we}, 32'b00);
    tick();
    check("fetch_still", 32'(state_o), 32'd1);
    mem_ready = 1'b1;
    #1;
    check("fetch_done", {29'd0, ir_we, pc_we, pc_sel}, 32'b110);

    // addi x1,x0,5
    cyc = 0; reg_we_cycles = 0;
    tick();
    check("addi_decode", 32'(state_o), 32'd2);
    check("addi_decode_quiet", {28'd0, mem_req, ir_we, pc_we, reg_we}, 32'd0);
    tick();
    check("addi_exec", 32'(state_o), 32'd3);
    check("addi_exec_cfg", {26'd0, imm_type, alu_a_sel, alu_b_sel, alu_op[0]}, {26'd0, 3'd0, 1'b0, 1'b1, 1'b1});
    check("addi_exec_op", 32'(alu_op), 32'd1);
    tick();
    check("addi_wb", 32'(state_o), 32'd5);
    check("addi_wb_cfg", {28'd0, wb_sel, pc_we, reg_we}, 32'b0001);
    tick();
    check("addi_back_fetch", 32'(state_o), 32'd1);
    check("addi_cpi", 32'(cyc), 32'd4);
    check("addi_reg_we_once", 32'(reg_we_cycles), 32'd1);

    // lw x2,0(x1) with two MEM wait states
    inst = 32'h0000A103; cyc = 0;
    tick();
    check("lw_decode", 32'(state_o), 32'd2);
    tick();
    check("lw_exec_cfg", {27'd0, alu_a_sel, alu_b_sel, alu_op, 1'b0}, {27'd0, 1'b0, 1'b1, 2'd0, 1'b0});
    mem_ready = 1'b0;
    tick();
    check("lw_mem1", {26'd0, state_o, mem_req, mem_is_data, mem_we}, {26'd0, 3'd4, 3'b110});
    tick();
    check("lw_mem2", {26'd0, state_o, mem_req, mem_is_data, mem_we}, {26'd0, 3'd4, 3'b110});
    tick();
    mem_ready = 1'b1;
    #1;
    check("lw_mem3", {26'd0, state_o, mem_req, mem_is_data, mem_we}, {26'd0, 3'd4, 3'b110});
    tick();
    check("lw_wb", {27'd0, state_o, wb_sel}, {27'd0, 3'd5, 2'd1});
    check("lw_wb_reg_we", 32'(reg_we), 32'd1);
    tick();
    check("lw_back_fetch", 32'(state_o), 32'd1);
    check("lw_cycles", 32'(cyc), 32'd7);

    // sw x2,0(x1)
    inst = 32'h0020A023; cyc = 0; reg_we_cycles = 0;
    tick();
    check("sw_imm", 32'(imm_type), 32'd1);
    tick();
    check("sw_exec", {29'd0, state_o}, 32'd3);
    tick();
    check("sw_mem", {26'd0, state_o, mem_req, mem_is_data, mem_we}, {26'd0, 3'd4, 3'b111});
    tick();
    check("sw_back_fetch", 32'(state_o), 32'd1);
    check("sw_cycles", 32'(cyc), 32'd4);
    check("sw_no_reg_we", 32'(reg_we_cycles), 32'd0);

    // beq taken then not taken
    inst = 32'h00000463; br_taken = 1'b1; cyc = 0;
    tick();
    check("beq_imm", 32'(imm_type), 32'd2);
    tick();
    check("beq_t_exec", {27'd0, state_o, pc_we, pc_sel}, {27'd0, 3'd3, 2'b11});
    check("beq_alu_a_pc", 32'(alu_a_sel), 32'd1);
    tick();
    check("beq_t_fetch", 32'(state_o), 32'd1);
    check("beq_t_cycles", 32'(cyc), 32'd3);
    br_taken = 1'b0; cyc = 0;
    tick();
    tick();
    check("beq_nt_exec", {28'd0, state_o, pc_we}, {28'd0, 3'd3, 1'b0});
    tick();
    check("beq_nt_fetch", 32'(state_o), 32'd1);
    check("beq_nt_cycles", 32'(cyc), 32'd3);

    // jal x1,16
    inst = 32'h010000EF; cyc = 0;
    tick();
    check("jal_imm", 32'(imm_type), 32'd4);
    tick();
    check("jal_exec_cfg", {28'd0, alu_a_sel, alu_b_sel, alu_op}, {28'd0, 1'b1, 1'b1, 2'd0});
    tick();
    check("jal_wb", {25'd0, state_o, reg_we, wb_sel, pc_we}, {25'd0, 3'd5, 1'b1, 2'd2, 1'b1});
    check("jal_wb_pc_sel", 32'(pc_sel), 32'd1);
    tick();
    check("jal_cycles", 32'(cyc), 32'd4);

    // store stalled in MEM, reset mid-cycle drops the request
    inst = 32'h0020A023;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("rstmem_in_mem", {26'd0, state_o, mem_req, mem_we, 1'b0}, {26'd0, 3'd4, 3'b110});
    #2;
    rst = 1'b1;
    #1;
    check("rstmem_state", 32'(state_o), 32'd0);
    check("rstmem_no_req", {30'd0, mem_req, mem_we}, 32'd0);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("rstmem_refetch", 32'(state_o), 32'd1);

    // illegal opcode traps and stays trapped
    inst = 32'h00000000;
    tick();
    check("ill_decode", 32'(state_o), 32'd2);
    tick();
    check("ill_trap_state", 32'(state_o), 32'd6);
    check("ill_trap_flag", 32'(trap), 32'd1);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    instret_snap = instret_cnt;
    cycle_snap   = cycle_cnt;
`endif
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trap !== 1'b1 || state_o !== 3'd6 || mem_req !== 1'b0 || reg_we !== 1'b0) bad++;
    end
    check("trap_held_100", 32'(bad), 32'd0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    check("trap_instret_frozen", instret_cnt, instret_snap);
    check("trap_cycle_frozen", cycle_cnt, cycle_snap);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("trap_rst_state", 32'(state_o), 32'd0);
    check("trap_rst_flag", 32'(trap), 32'd0);
`ifdef MULTI_CYCLE_CTRL_PERF_EN
    check("rst_instret_zero", instret_cnt, 32'd0);
`endif
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control FSM for the multi-cycle RV32I core that runs the FFT/IFFT kernels. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the strobes for the PC, the instruction register, the register file and the data memory. It also selects the immediate format fed to the immediate generator and configures the ALU operand muxes and operation.

## Interface
Parameters:
- `FETCH_TIMEOUT`, default 0: reserved, must stay 0 (no timeout); presence only.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst` in `instWidth` (32): current instruction-register contents.
- `br_taken` in 1: branch-comparator result, valid in EXEC.
- `mem_ready` in 1: memory handshake done (fetch or data).
- `mem_req` out 1: memory access request.
- `mem_we` out 1: data-memory write (store).
- `mem_is_data` out 1: 0 = instruction port, 1 = data port.
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: PC write enable.
- `pc_sel` out 1: 0 = PC+4, 1 = ALU result register.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = PC+4 link.
- `alu_a_sel` out 1: 0 = rs1, 1 = PC.
- `alu_b_sel` out 1: 0 = rs2, 1 = immediate.
- `alu_op` out 2: 0 = ADD, 1 = FUNCT (ALU decodes funct3/funct7), 2 = PASS_B.
- `imm_type` out 3: I=0, S=1, B=2, U=3, J=4.
- `trap` out 1: sticky illegal-opcode flag.
- `state_o` out 3: current state, for debug.

## Operation
States are IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: reset state. All strobes are 0. Goes unconditionally to FETCH on the next edge.
- FETCH: `mem_req`=1, `mem_is_data`=0. Waits while `mem_ready`=0. When `mem_ready`=1: `ir_we`=1, `pc_we`=1 with `pc_sel`=0, next state is DECODE.
- DECODE: no strobes. Classifies `inst[6:0]`.
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Next state is EXEC.
  - Any other opcode: next state is TRAP.
- EXEC: operand and ALU configuration per opcode.
  - OP: a=rs1, b=rs2, FUNCT.
  - OP-IMM: a=rs1, b=imm, FUNCT.
  - LOAD/STORE: a=rs1, b=imm, ADD.
  - LUI: b=imm, PASS_B.
  - AUIPC/JAL/BRANCH: a=PC, b=imm, ADD.
  - JALR: a=rs1, b=imm, ADD.
  - Next state: BRANCH returns to FETCH, with `pc_we`=`br_taken` and `pc_sel`=1. LOAD/STORE go to MEM. All others go to WB.
  - Branch target uses the PC, which already holds PC+4, so the ALU A input must be the pre-increment PC. This means `alu_a_sel`=1 selects the old-PC register that is latched with `ir_we`.
- MEM: `mem_req`=1, `mem_is_data`=1, `mem_we`=1 for STORE. Waits on `mem_ready`. When it arrives: STORE goes to FETCH, LOAD goes to WB.
- WB: `reg_we`=1. `wb_sel` is 1 for LOAD, 2 for JAL/JALR, 0 otherwise. JAL/JALR also assert `pc_we`=1 with `pc_sel`=1. Next state is FETCH.
- TRAP: absorbing until `rst`; `trap`=1, all strobes 0.
- `imm_type` is decoded from `inst[6:0]` in every state; it is a don't-care for OP. Mapping: I for LOAD/OP-IMM/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL.
- All outputs are combinational from the state register and `inst`. The only flops are the state register and the optional counters.

## Timing
- Reset: `rst`=1 forces IDLE asynchronously. All outputs are then 0, except `imm_type` (decode of `inst`) and `state_o`=0.
- Reset asserted mid-MEM drops `mem_req` in the same cycle. No write is completed.
- Cycles per instruction with zero wait states:
  - BRANCH: 3.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - STORE: 4.
  - LOAD: 5.
- Each cycle of `mem_ready`=0 adds one cycle in FETCH or MEM.
- `mem_req` stays high and stable, with the same `mem_we` and `mem_is_data`, until the cycle `mem_ready`=1 is sampled.
- `mem_ready` outside FETCH/MEM is ignored.

## Configuration
- `MULTI_CYCLE_CTRL_PERF_EN` defined: adds two outputs.
  - `cycle_cnt` (out 32): increments every cycle outside IDLE.
  - `instret_cnt` (out 32): increments on every transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^32, reset to 0, and freeze in TRAP.
- Undefined: these ports and counters do not exist.

## Structure
- State encodings, `alu_op`, `wb_sel` and `imm_type` codes, and the opcode constants go in `define.v`, shared with the immediate generator and the ALU.
- One sub-module, `opcode_decode`, is combinational. It maps `inst[6:0]` to a one-hot class plus `imm_type` and a legal flag.

## Test plan
- `addi x1,x0,5` (0x00500093), `mem_ready` tied 1 after reset release -> states 1,2,3,5,1. `imm_type`=0, `alu_b_sel`=1, `alu_op`=1. `reg_we` is high for exactly 1 cycle.
- `lw x2,0(x1)` (0x0000A103) with `mem_ready` low for 2 cycles in MEM -> MEM lasts 3 cycles with `mem_req`=1 and `mem_we`=0 throughout. WB has `wb_sel`=1. Total 7 cycles.
- `sw x2,0(x1)` (0x0020A023) -> `imm_type`=1 and `mem_we`=1 in MEM. No `reg_we`. Back to FETCH after 4 cycles.
- `beq x0,x0,8` (0x00000463): with `br_taken`=1, EXEC has `pc_we`=1 and `pc_sel`=1. With `br_taken`=0, EXEC has `pc_we`=0. Both return to FETCH after 3 cycles.
- `jal x1,16` (0x010000EF) -> WB has `reg_we`=1, `wb_sel`=2, `pc_we`=1 and `pc_sel`=1. `imm_type`=4.
- Opcode 0x00000000 -> TRAP after DECODE, `trap`=1 held for 100 cycles. Then `rst` pulsed mid-cycle -> IDLE immediately, `trap`=0. With `MULTI_CYCLE_CTRL_PERF_EN`, `instret_cnt` stays frozen while in TRAP.
